// File: rtl/spi_mon_pkg.sv
// Shared types and constants for the SPI overload monitor.
// The overload code values match the encoding used by the overload hex driver.
package spi_mon_pkg;

    // Receive FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } spi_state_e;

    localparam logic [3:0] OVL_CODE_LOW  = 4'h0;
    localparam logic [3:0] OVL_CODE_HIGH = 4'h1;

    // Map the internal overload bit onto the hex driver's two codes.
    function automatic logic [3:0] ovl_encode(input logic ovl);
        return ovl ? OVL_CODE_HIGH : OVL_CODE_LOW;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with rise/fall pulse detection.
// Edges are suppressed until the chain and the previous-level flop hold real
// samples taken after reset, so the reset fill level never fakes an edge.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   valid_q;

    // Shift the asynchronous input through the chain and track sample validity.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            valid_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = valid_q[SYNC_STAGES] &  level_o & ~prev_q;
    assign fall_o  = valid_q[SYNC_STAGES] & ~level_o &  prev_q;

endmodule

// File: rtl/spi_overload_monitor.sv
// SPI mode-0 receive monitor with valid/ack handoff and overload indication.
// Build option: define SPI_OVL_STICKY_EN for a sticky overload flag cleared by
// ovl_clr; otherwise the overload is stretched for HOLD_CYCLES clocks.
//
// state | meaning
// IDLE  | waiting for a chip-select falling edge
// SHIFT | collecting MOSI bits on SCLK rising edges
// LOAD  | one cycle: publish byte, bump count, check for overload
module spi_overload_monitor
    import spi_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    input  logic             rd_ack,
    input  logic             ovl_clr,
    output logic [7:0]       rx_byte,
    output logic             rx_valid,
    output logic [CNT_W-1:0] byte_count,
    output logic [3:0]       ovl_code
);

    logic sclk_rise, cs_level, cs_fall, mosi_level;
    logic unused_sclk_level, unused_sclk_fall, unused_cs_rise;
    logic unused_mosi_rise, unused_mosi_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(Clk), .rst_i(Reset), .d_i(spi_sclk),
        .level_o(unused_sclk_level), .rise_o(sclk_rise), .fall_o(unused_sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(Clk), .rst_i(Reset), .d_i(spi_cs_n),
        .level_o(cs_level), .rise_o(unused_cs_rise), .fall_o(cs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(Clk), .rst_i(Reset), .d_i(spi_mosi),
        .level_o(mosi_level), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
    );

    spi_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovl_q, ovl_d;
    logic             ovl_evt;

    // Receive FSM, byte handoff and overload event detection.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_byte_d  = rx_byte_q;
        count_d    = count_q;
        ovl_evt    = 1'b0;
        rx_valid_d = rx_valid_q;
        if (rd_ack) begin
            rx_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (cs_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_level) begin
                    // Frame ended before the byte completed: drop it silently.
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[6:0], mosi_level};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            LOAD: begin
                rx_byte_d  = shift_q;
                count_d    = count_q + CNT_W'(1);
                ovl_evt    = rx_valid_q & ~rd_ack;
                rx_valid_d = 1'b1;
                state_d    = cs_level ? IDLE : SHIFT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register the FSM, data path and overload indication.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            count_q    <= '0;
            ovl_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            count_q    <= count_d;
            ovl_q      <= ovl_d;
        end
    end

`ifdef SPI_OVL_STICKY_EN
    // Sticky flag: an event in the same cycle as a clear keeps it set.
    always_comb begin
        ovl_d = ovl_evt | (ovl_q & ~ovl_clr);
    end
`else
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              unused_ovl_clr;

    assign unused_ovl_clr = ovl_clr;

    // Stretch timer: reload on every event, count down to zero and stay there.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (ovl_evt) begin
            hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
        ovl_d = ovl_evt | (hold_cnt_q != '0);
    end

    // Register the stretch timer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign byte_count = count_q;
    assign ovl_code   = ovl_encode(ovl_q);

endmodule

// File: tb/tb_spi_overload_monitor.sv
// Directed bench for spi_overload_monitor with a pin-level reference model.
module tb_spi_overload_monitor;

    localparam int S    = 2;
    localparam int HOLD = 10;
    localparam int CW   = 4;
    localparam int HALF = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          spi_sclk = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          rd_ack = 1'b0;
    logic          ovl_clr = 1'b0;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic [CW-1:0] byte_count;
    logic [3:0]    ovl_code;

    spi_overload_monitor #(.SYNC_STAGES(S), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .rd_ack(rd_ack), .ovl_clr(ovl_clr),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .byte_count(byte_count),
        .ovl_code(ovl_code)
    );

    always #5 Clk = ~Clk;

    int vec  = 0;
    int miss = 0;
    int ovl_cycles = 0;

    // Reference model: pin samples per clock, bytes scheduled S+1 clocks after
    // the sample that showed the 8th SCLK rise.
    int            edge_k = 0;
    bit            m_ready = 0;
    logic          m_valid;
    logic [7:0]    m_byte;
    logic [CW-1:0] m_count;
    int            m_ovl_until;
    logic          m_flag;
    logic          p_cs, p_sclk;
    bit            framed, m_evt;
    int            nbits;
    logic [7:0]    acc;
    int            pend_e[$];
    logic [7:0]    pend_b[$];

    initial begin
        forever begin
            @(posedge Clk);
            edge_k = edge_k + 1;
            if (Reset) begin
                m_valid = 0; m_byte = '0; m_count = '0; m_flag = 0;
                m_ovl_until = -1000;
                p_cs = 0; p_sclk = 0; framed = 0; nbits = 0; acc = '0;
                pend_e.delete(); pend_b.delete();
                m_ready = 1;
            end else begin
                m_evt = 0;
                if (pend_e.size() > 0 && pend_e[0] == edge_k) begin
                    m_evt   = m_valid && !rd_ack;
                    m_byte  = pend_b[0];
                    m_count = m_count + 1'b1;
                    m_valid = 1;
                    void'(pend_e.pop_front());
                    void'(pend_b.pop_front());
                end else if (m_valid && rd_ack) begin
                    m_valid = 0;
                end
                if (m_evt) begin
                    m_ovl_until = edge_k + HOLD - 1;
                    m_flag = 1;
                end else if (ovl_clr) begin
                    m_flag = 0;
                end
                if (spi_cs_n) begin
                    framed = 0; nbits = 0;
                end else if (p_cs) begin
                    framed = 1; nbits = 0;
                end else if (framed && spi_sclk && !p_sclk) begin
                    acc = {acc[6:0], spi_mosi};
                    nbits = nbits + 1;
                    if (nbits == 8) begin
                        pend_e.push_back(edge_k + S + 1);
                        pend_b.push_back(acc);
                        nbits = 0;
                    end
                end
                p_cs = spi_cs_n;
                p_sclk = spi_sclk;
            end
        end
    end

    function automatic logic [3:0] exp_code();
`ifdef SPI_OVL_STICKY_EN
        return m_flag ? 4'h1 : 4'h0;
`else
        return (edge_k <= m_ovl_until) ? 4'h1 : 4'h0;
`endif
    endfunction

    // Per-cycle comparison against the model, plus overload-cycle counting.
    initial begin
        forever begin
            @(negedge Clk);
            if (ovl_code == 4'h1) ovl_cycles = ovl_cycles + 1;
            if (m_ready) begin
                vec = vec + 1;
                if ({rx_valid, rx_byte, byte_count, ovl_code} !==
                    {m_valid, m_byte, m_count, exp_code()}) begin
                    miss = miss + 1;
                    if (miss <= 20)
                        $display("FAIL cycle_compare @%0d: dut valid=%0b byte=%h count=%h code=%h, model valid=%0b byte=%h count=%h code=%h",
                                 edge_k, rx_valid, rx_byte, byte_count, ovl_code,
                                 m_valid, m_byte, m_count, exp_code());
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec = vec + 1;
        if (act !== exp) begin
            miss = miss + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        cycles(3);
        Reset = 1'b0;
        cycles(2);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit ack_on_load);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            cycles(HALF);
            spi_sclk = 1'b1;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge Clk);
                if (ack_on_load && i == 0) rd_ack = (c == S + 1);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic start_frame();
        spi_cs_n = 1'b0;
        cycles(4);
    endtask

    task automatic end_frame();
        cycles(4);
        spi_cs_n = 1'b1;
        cycles(6);
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        cycles(1);
        rd_ack = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_count", 32'(byte_count), 32'd0);
        cycles(4);

        // Reset in the middle of a frame, then a clean 0xA5 frame.
        start_frame();
        send_bits(8'hFF, 4, 0);
        Reset = 1'b1;
        cycles(3);
        Reset = 1'b0;
        cycles(8);
        check("midreset_valid", 32'(rx_valid), 32'd0);
        check("midreset_count", 32'(byte_count), 32'd0);
        spi_cs_n = 1'b1;
        cycles(6);
        start_frame();
        send_bits(8'hA5, 8, 0);
        end_frame();
        check("a5_byte", 32'(rx_byte), 32'hA5);
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_count", 32'(byte_count), 32'd1);
        check("a5_code", 32'(ovl_code), 32'h0);

        // Two bytes in one frame with an ack between them.
        do_reset();
        cycles(4);
        ovl_cycles = 0;
        start_frame();
        send_bits(8'h3C, 8, 0);
        pulse_ack();
        send_bits(8'hC3, 8, 0);
        end_frame();
        check("acked_count", 32'(byte_count), 32'd2);
        check("acked_byte", 32'(rx_byte), 32'hC3);
        check("acked_ovl_cycles", 32'(ovl_cycles), 32'd0);

        // Same two bytes without an ack: overload.
        do_reset();
        cycles(4);
        ovl_cycles = 0;
        start_frame();
        send_bits(8'h3C, 8, 0);
        send_bits(8'hC3, 8, 0);
        end_frame();
        cycles(20);
        check("ovl_byte", 32'(rx_byte), 32'hC3);
`ifdef SPI_OVL_STICKY_EN
        check("ovl_sticky_code", 32'(ovl_code), 32'h1);
`else
        check("ovl_stretch_cycles", 32'(ovl_cycles), 32'd10);
        check("ovl_stretch_end", 32'(ovl_code), 32'h0);
`endif

        // Partial 5-bit frame dropped, then 0x81.
        do_reset();
        cycles(4);
        start_frame();
        send_bits(8'hFF, 5, 0);
        spi_cs_n = 1'b1;
        cycles(10);
        check("partial_valid", 32'(rx_valid), 32'd0);
        check("partial_count", 32'(byte_count), 32'd0);
        start_frame();
        send_bits(8'h81, 8, 0);
        end_frame();
        check("b81_byte", 32'(rx_byte), 32'h81);
        check("b81_count", 32'(byte_count), 32'd1);

        // Ack coincident with the second LOAD.
        do_reset();
        cycles(4);
        ovl_cycles = 0;
        start_frame();
        send_bits(8'h3C, 8, 0);
        send_bits(8'h5A, 8, 1);
        end_frame();
        check("coack_valid", 32'(rx_valid), 32'd1);
        check("coack_byte", 32'(rx_byte), 32'h5A);
        check("coack_ovl_cycles", 32'(ovl_cycles), 32'd0);

        // 17 unacked bytes: counter wraps, overload repeatedly raised.
        do_reset();
        cycles(4);
        start_frame();
        for (int i = 0; i < 17; i++) send_bits(8'h10 + 8'(i), 8, 0);
        end_frame();
        check("wrap_count", 32'(byte_count), 32'h1);
        check("wrap_byte", 32'(rx_byte), 32'h20);
        cycles(HOLD + 5);
`ifdef SPI_OVL_STICKY_EN
        check("sticky_held", 32'(ovl_code), 32'h1);
        ovl_clr = 1'b1;
        cycles(1);
        ovl_clr = 1'b0;
        check("sticky_cleared", 32'(ovl_code), 32'h0);
        cycles(3);
        check("sticky_stays_clear", 32'(ovl_code), 32'h0);
`else
        check("stretch_expired", 32'(ovl_code), 32'h0);
        ovl_clr = 1'b1;
        cycles(1);
        ovl_clr = 1'b0;
        check("clr_ignored", 32'(ovl_code), 32'h0);
`endif
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/spi_overload_monitor.md
Name: spi_overload_monitor

Overview:
- SPI mode-0 slave receive monitor that sits directly upstream of the two-state overload hex driver.
- Deserialises MOSI bytes while the FPGA SCLK and CS_n inputs are oversampled in the Clk domain.
- Hands each byte to a consumer with a valid/ack pair.
- Flags an overload when a new byte completes while the previous one is still unacknowledged.
- Emits ovl_code: 4'h0 means no overload (bottom dash), 4'h1 means overload (top dash), stretched so a human can see it.

Parameters:
- SYNC_STAGES, 2, flip-flop synchroniser depth for sclk, cs_n and mosi (minimum 2).
- HOLD_CYCLES, 25_000_000, Clk cycles ovl_code stays 4'h1 after an overload event (0.5 s at 50 MHz).
- CNT_W, 16, width of the byte counter.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  asynchronous SPI clock from the master.
- spi_cs_n  in  1  asynchronous chip select, active low.
- spi_mosi  in  1  asynchronous serial data, MSB first.
- rd_ack  in  1  consumer has taken rx_byte; only meaningful while rx_valid=1.
- ovl_clr  in  1  clears the sticky overload (used only under the macro).
- rx_byte  out  8  last completed byte.
- rx_valid  out  1  rx_byte holds an unread byte.
- byte_count  out  CNT_W  bytes completed since reset; wraps modulo 2^CNT_W.
- ovl_code  out  4  4'h0 = no overload, 4'h1 = overload; no other values are ever driven.

Behaviour:
- Reset (synchronous, one cycle suffices), all to zero:
  - rx_byte=0, rx_valid=0, byte_count=0, ovl_code=4'h0.
  - Shift register, bit counter and hold counter = 0.
  - Synchroniser chains filled with the idle levels: sclk=0, cs_n=1.
  - FSM = IDLE.
  - Reset mid-frame discards the partial byte. Shifting resumes only after cs_n is seen high and then a new falling edge.
- Synchronisation and edge detection:
  - Each SPI input passes through SYNC_STAGES flops.
  - An sclk rise is synced_sclk=1 with the previous synced_sclk=0.
  - A cs fall is the same detection applied to synced cs_n going 1→0.
  - SCLK must be ≤ Clk/4. Faster SCLK is out of spec and produces undefined data, though the block must not hang.
- FSM:
  - IDLE: bit counter=0. A cs fall moves to SHIFT.
  - SHIFT: on each sclk rise, shift = {shift[6:0], mosi_sync} and the bit counter increments.
    - When the 8th bit is shifted in, the byte completes: go to LOAD next cycle and reset the bit counter to 0.
    - If cs_n goes high with the bit counter at 1..7, drop the partial byte, go to IDLE, and raise no event.
  - LOAD (exactly one cycle):
    - rx_byte ← shift and byte_count ← byte_count+1.
    - If rx_valid=1 and rd_ack=0 in this cycle: overload event; rx_byte is still overwritten (newest byte wins).
    - rx_valid ← 1.
    - Next state is SHIFT if cs_n is low, otherwise IDLE. This supports back-to-back bytes within one CS frame.
- rx_valid/rd_ack:
  - rx_valid clears on the cycle after rd_ack=1 while rx_valid=1.
  - If rd_ack=1 in the same cycle as LOAD, the old byte counts as read: no overload, and rx_valid stays 1 with the new byte.
  - rd_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises SYNC_STAGES+2 Clk cycles after the 8th SCLK rising edge at the pin, ±1 cycle of synchroniser uncertainty.
- Overload stretching (default build):
  - An event loads hold_cnt=HOLD_CYCLES-1. ovl_code=4'h1 whenever the event occurs this cycle or hold_cnt≠0.
  - hold_cnt decrements to 0 and then holds at 0.
  - A new event during the hold reloads the counter.
  - ovl_code is registered, so it goes 4'h1 one cycle after LOAD.
- byte_count wraps from 2^CNT_W-1 to 0 silently.

Optional Feature:
- Macro: SPI_OVL_STICKY_EN.
- Defined:
  - The overload is a sticky flag, set by an event.
  - Cleared only by Reset or ovl_clr=1; ovl_code=4'h0 on the next cycle.
  - An event in the same cycle as ovl_clr wins, so the flag stays set.
  - The hold counter is not synthesised.
- Undefined: the stretch behaviour above applies and ovl_clr is ignored.

Decomposition:
- Package spi_mon_pkg holds:
  - The FSM enum typedef (IDLE, SHIFT, LOAD).
  - Constants OVL_CODE_LOW=4'h0 and OVL_CODE_HIGH=4'h1, shared with the hex driver's encoding.
- One sub-module: sync_edge_det (parameter SYNC_STAGES, reset level).
  - Outputs the synced level plus rise and fall pulses.
  - Instantiated three times; the mosi instance uses only the level.

Test Plan:
- Reset held 3 cycles during an active frame, then a clean 0xA5 frame → the partial byte is never presented; rx_byte=8'hA5, rx_valid=1, byte_count=1, ovl_code=4'h0.
- Two bytes 0x3C, 0xC3 in one CS frame, with rd_ack pulsed between them → two LOAD cycles, byte_count=2, rx_byte=8'hC3, ovl_code stays 4'h0.
- Same two bytes with no rd_ack, HOLD_CYCLES=10 → rx_byte=8'hC3; ovl_code=4'h1 for exactly 10 cycles after LOAD, then 4'h0.
- cs_n raised after 5 SCLK edges, then a full 0x81 frame → no LOAD for the partial byte; rx_byte=8'h81, byte_count=1.
- rd_ack asserted in the same cycle as the second LOAD → no overload; rx_valid stays 1 and rx_byte holds the new byte.
- With SPI_OVL_STICKY_EN, CNT_W=4, run 17 bytes with no ack → byte_count=4'h1; ovl_code stays 4'h1 until ovl_clr, then 4'h0 the next cycle.
